sram_dp_param: RTL and testbench

SRAM_DP_PARAM -- requirements
Module: sram_dp_param

---
 rtl/sram_dp_param.sv | 156 +++++++++++++++
 tb/tb_sram_dp_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_param.sv
// Dual-port word SRAM that fills itself with INIT_VAL after reset, then serves two read-first ports.
// Optional per-word even parity with error injection when SRAM_DP_PARITY_EN is defined.
module sram_dp_param #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter logic [DW-1:0] INIT_VAL = DW'(32'd250)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CEB1,
  input  logic          CEB2,
  input  logic          CMD1,
  input  logic          CMD2,
  input  logic [AW-1:0] ADD1,
  input  logic [AW-1:0] ADD2,
  input  logic [DW-1:0] DIN1,
  input  logic [DW-1:0] DIN2,
  output logic [DW-1:0] Q1,
  output logic [DW-1:0] Q2,
  output logic          READY,
  output logic          COLL
`ifdef SRAM_DP_PARITY_EN
  ,
  input  logic          ERRINJ,
  output logic          PERR1,
  output logic          PERR2
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

  logic [0:0]    state_r;
  logic [AW-1:0] cnt_r;
  logic [DW-1:0] mem_r [0:DEPTH-1];

  logic run_s;
  logic wr1_s;
  logic wr2_s;
  logic rd1_s;
  logic rd2_s;
  logic coll_s;

  function automatic logic parity_f(input logic [DW-1:0] data);
    return ^data;
  endfunction

`ifdef SRAM_DP_PARITY_EN
  logic par_r [0:DEPTH-1];

  function automatic logic parity_bad_f(input logic [DW-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction
`endif

  // Per-port access decode; nothing is honoured outside RUN
  always_comb begin
    run_s  = 1'b0;
    wr1_s  = 1'b0;
    wr2_s  = 1'b0;
    rd1_s  = 1'b0;
    rd2_s  = 1'b0;
    coll_s = 1'b0;
    if (state_r == ST_RUN) begin
      run_s  = 1'b1;
      wr1_s  = ~CEB1 & ~CMD1;
      wr2_s  = ~CEB2 & ~CMD2;
      rd1_s  = ~CEB1 & CMD1;
      rd2_s  = ~CEB2 & CMD2;
      coll_s = ~CEB1 & ~CEB2 & (ADD1 == ADD2) & (~CMD1 | ~CMD2);
    end else begin
      run_s  = 1'b0;
    end
  end

  // Init sequencer: one fill write per cycle, RUN entered on the last address
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_INIT;
      cnt_r   <= {AW{1'b0}};
      READY   <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_RUN;
            READY   <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          READY   <= 1'b1;
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= {AW{1'b0}};
          READY   <= 1'b0;
        end
      endcase
    end
  end

  // Array writes; port 2 is applied first so port 1 wins a same-address write
  always_ff @(posedge CLK) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r] <= INIT_VAL;
`ifdef SRAM_DP_PARITY_EN
      par_r[cnt_r] <= parity_f(INIT_VAL);
`endif
    end else begin
      if (wr2_s) begin
        mem_r[ADD2] <= DIN2;
`ifdef SRAM_DP_PARITY_EN
        par_r[ADD2] <= parity_f(DIN2) ^ ERRINJ;
`endif
      end
      if (wr1_s) begin
        mem_r[ADD1] <= DIN1;
`ifdef SRAM_DP_PARITY_EN
        par_r[ADD1] <= parity_f(DIN1) ^ ERRINJ;
`endif
      end
    end
  end

  // Read registers sample the pre-write array contents, giving read-first behaviour
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      Q1   <= {DW{1'b0}};
      Q2   <= {DW{1'b0}};
      COLL <= 1'b0;
`ifdef SRAM_DP_PARITY_EN
      PERR1 <= 1'b0;
      PERR2 <= 1'b0;
`endif
    end else begin
      COLL <= coll_s & run_s;
      if (rd1_s) begin
        Q1 <= mem_r[ADD1];
`ifdef SRAM_DP_PARITY_EN
        PERR1 <= parity_bad_f(mem_r[ADD1], par_r[ADD1]);
`endif
      end
      if (rd2_s) begin
        Q2 <= mem_r[ADD2];
`ifdef SRAM_DP_PARITY_EN
        PERR2 <= parity_bad_f(mem_r[ADD2], par_r[ADD2]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_param.sv
// Directed table-driven bench for sram_dp_param (DW=8, AW=4), plus reset and parity sequences.
module tb_sram_dp_param;

  logic       clk;
  logic       rstn;
  logic       ceb1, ceb2, cmd1, cmd2;
  logic [3:0] add1, add2;
  logic [7:0] din1, din2;
  logic [7:0] q1, q2;
  logic       ready, coll;
`ifdef SRAM_DP_PARITY_EN
  logic       errinj;
  logic       perr1, perr2;
`endif

  int n_vec = 0;
  int n_bad = 0;

  sram_dp_param #(.DW(8), .AW(4), .INIT_VAL(8'd250)) dut (
    .CLK(clk), .RSTN(rstn),
    .CEB1(ceb1), .CEB2(ceb2), .CMD1(cmd1), .CMD2(cmd2),
    .ADD1(add1), .ADD2(add2), .DIN1(din1), .DIN2(din2),
    .Q1(q1), .Q2(q2), .READY(ready), .COLL(coll)
`ifdef SRAM_DP_PARITY_EN
    , .ERRINJ(errinj), .PERR1(perr1), .PERR2(perr2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ceb1, cmd1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       ceb2, cmd2;
    logic [3:0] a2;
    logic [7:0] d2;
    logic [7:0] q1, q2;
    logic       coll;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c1, input logic m1, input logic [3:0] a1, input logic [7:0] d1,
                              input logic c2, input logic m2, input logic [3:0] a2, input logic [7:0] d2,
                              input logic [7:0] e1, input logic [7:0] e2, input logic ec);
    vec_t v;
    v.ceb1 = c1; v.cmd1 = m1; v.a1 = a1; v.d1 = d1;
    v.ceb2 = c2; v.cmd2 = m2; v.a2 = a2; v.d2 = d2;
    v.q1 = e1; v.q2 = e2; v.coll = ec;
    return v;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic idle();
    ceb1 = 1'b1; cmd1 = 1'b1; add1 = 4'd0; din1 = 8'd0;
    ceb2 = 1'b1; cmd2 = 1'b1; add2 = 4'd0; din2 = 8'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk1("ready_timeout", got, 1'b1);
  endtask

  initial begin
    rstn = 1'b0;
`ifdef SRAM_DP_PARITY_EN
    errinj = 1'b0;
`endif
    idle();

    for (int a = 0; a < 16; a++)
      tbl.push_back(mk(1'b0, 1'b1, 4'(a), 8'h00, 1'b1, 1'b1, 4'd0, 8'h00, 8'd250, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd3,  8'h5A, 1'b1, 1'b1, 4'd0,  8'h00, 8'hFA, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 1'b1, 4'd3,  8'h00, 8'hFA, 8'h5A, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd7,  8'h11, 1'b1, 1'b1, 4'd0,  8'h00, 8'hFA, 8'h5A, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd7,  8'h22, 1'b0, 1'b1, 4'd7,  8'h00, 8'hFA, 8'h11, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 4'd0,  8'h00, 1'b1, 1'b1, 4'd0,  8'h00, 8'hFA, 8'h11, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd7,  8'h00, 1'b1, 1'b1, 4'd0,  8'h00, 8'h22, 8'h11, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd9,  8'hAA, 1'b0, 1'b0, 4'd9,  8'h55, 8'h22, 8'h11, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 4'd0,  8'h00, 1'b1, 1'b1, 4'd0,  8'h00, 8'h22, 8'h11, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 1'b1, 4'd9,  8'h00, 8'h22, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd9,  8'h00, 1'b0, 1'b1, 4'd9,  8'h00, 8'hAA, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd3,  8'h00, 1'b0, 1'b0, 4'd14, 8'h0E, 8'h5A, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd14, 8'h00, 1'b1, 1'b1, 4'd0,  8'h00, 8'h0E, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 4'd3,  8'hFF, 1'b1, 1'b1, 4'd0,  8'h00, 8'h0E, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd3,  8'h00, 1'b1, 1'b1, 4'd0,  8'h00, 8'h5A, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd6,  8'h66, 1'b1, 1'b1, 4'd6,  8'h00, 8'h5A, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 1'b1, 4'd6,  8'h00, 8'h5A, 8'h66, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd6,  8'h00, 1'b0, 1'b0, 4'd6,  8'h77, 8'h66, 8'h66, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'd6,  8'h00, 1'b1, 1'b1, 4'd0,  8'h00, 8'h77, 8'h66, 1'b0));

    // Reset state while RSTN is held low
    repeat (3) @(negedge clk);
    chk8("rst_q1", q1, 8'h00);
    chk8("rst_q2", q2, 8'h00);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_coll", coll, 1'b0);

    // Accesses during INIT must be ignored (colliding write/read of address 1)
    ceb1 = 1'b0; cmd1 = 1'b0; add1 = 4'd1; din1 = 8'h99;
    ceb2 = 1'b0; cmd2 = 1'b1; add2 = 4'd1;
    rstn = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      chk1($sformatf("init_ready[%0d]", i), ready, (i == 16) ? 1'b1 : 1'b0);
      if (i < 16) begin
        chk1($sformatf("init_coll[%0d]", i), coll, 1'b0);
        chk8($sformatf("init_q2[%0d]", i), q2, 8'h00);
        step();
      end
    end
    idle();

    foreach (tbl[i]) begin
      ceb1 = tbl[i].ceb1; cmd1 = tbl[i].cmd1; add1 = tbl[i].a1; din1 = tbl[i].d1;
      ceb2 = tbl[i].ceb2; cmd2 = tbl[i].cmd2; add2 = tbl[i].a2; din2 = tbl[i].d2;
      step();
      chk8($sformatf("v%0d_q1", i), q1, tbl[i].q1);
      chk8($sformatf("v%0d_q2", i), q2, tbl[i].q2);
      chk1($sformatf("v%0d_coll", i), coll, tbl[i].coll);
    end
    idle();
    step();
    chk1("coll_single_pulse", coll, 1'b0);

    // Reset in mid-RUN restarts initialisation
    ceb1 = 1'b0; cmd1 = 1'b0; add1 = 4'd5; din1 = 8'h33;
    step();
    cmd1 = 1'b1;
    step();
    chk8("rd5_before_rst", q1, 8'h33);
    #2 rstn = 1'b0;
    #1;
    chk8("async_rst_q1", q1, 8'h00);
    chk1("async_rst_ready", ready, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    idle();
    step();
    chk1("reinit_ready_low", ready, 1'b0);
    wait_ready();
    ceb1 = 1'b0; cmd1 = 1'b1; add1 = 4'd5;
    step();
    chk8("rd5_after_reinit", q1, 8'd250);
    idle();

`ifdef SRAM_DP_PARITY_EN
    ceb1 = 1'b0; cmd1 = 1'b0; add1 = 4'd2; din1 = 8'h01; errinj = 1'b1;
    step();
    cmd1 = 1'b1; errinj = 1'b0;
    step();
    chk8("par_inj_q1", q1, 8'h01);
    chk1("par_inj_perr1", perr1, 1'b1);
    cmd1 = 1'b0;
    step();
    cmd1 = 1'b1;
    step();
    chk8("par_clean_q1", q1, 8'h01);
    chk1("par_clean_perr1", perr1, 1'b0);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
